// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, UartTX and uart_tx_arbiter.
// The arbiter uses the slave modport; the requester/TX side uses master.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   reqIN;
  logic [8*NREQ-1:0] dataIN;
  logic [NREQ-1:0]   grantOUT;
  logic [NREQ-1:0]   ackOUT;
  logic [7:0]        txDataOUT;
  logic              txSendOUT;
  logic              txNBusyIN;
  logic              busyOUT;
  logic              errOUT;

  modport slave (
    input  reqIN, dataIN, txNBusyIN,
    output grantOUT, ackOUT, txDataOUT, txSendOUT, busyOUT, errOUT
  );

  modport master (
    output reqIN, dataIN, txNBusyIN,
    input  grantOUT, ackOUT, txDataOUT, txSendOUT, busyOUT, errOUT
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTX between NREQ byte producers.
// Optional per-phase watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             baudClkX2,
  input  logic             resetIN,
  uart_tx_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, SEND, DONE, RELEASE} state_e;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1 || TIMEOUT > 256) begin : g_bad_cfg
    $error("uart_tx_arbiter: NREQ must be 2..8 and TIMEOUT 1..256");
  end

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [7:0]      data_q, data_d;
  logic            send_q, send_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;

  logic [PW-1:0]   pick;
  logic            found;
  logic [PW-1:0]   next_ptr;
  logic            timeout_hit;

  // Search starts at ptr and wraps, so the last owner is considered last.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.reqIN[idx]) begin
        found = 1'b1;
        pick  = idx[PW-1:0];
      end
    end
  end

  assign next_ptr = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign timeout_hit = (cnt_q == 8'(TIMEOUT - 1));

  // Counter restarts on every state change, so SEND and DONE each get a full budget.
  always_comb begin
    cnt_d = '0;
    if ((state_q == SEND || state_q == DONE) && state_d == state_q) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge baudClkX2) begin
    if (resetIN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    data_d  = data_q;
    send_d  = send_q;
    err_d   = 1'b0;
    ptr_d   = ptr_q;
    owner_d = owner_q;

    case (state_q)
      IDLE: begin
        if (bus.txNBusyIN && found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          data_d        = bus.dataIN[8*pick +: 8];
          send_d        = 1'b1;
          owner_d       = pick;
          state_d       = SEND;
        end
      end
      SEND: begin
        if (!bus.txNBusyIN) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          send_d  = 1'b0;
          grant_d = '0;
          err_d   = 1'b1;
          ptr_d   = next_ptr;
          state_d = RELEASE;
        end
      end
      DONE: begin
        if (bus.txNBusyIN) begin
          send_d         = 1'b0;
          grant_d        = '0;
          ack_d[owner_q] = 1'b1;
          ptr_d          = next_ptr;
          state_d        = RELEASE;
        end else if (timeout_hit) begin
          send_d  = 1'b0;
          grant_d = '0;
          err_d   = 1'b1;
          ptr_d   = next_ptr;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: non-blocking assignments make every flop update from pre-edge values, independent of statement order.
  always_ff @(posedge baudClkX2) begin
    if (resetIN) begin
      state_q <= IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      data_q  <= 8'h00;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus.grantOUT  = grant_q;
  assign bus.ackOUT    = ack_q;
  assign bus.txDataOUT = data_q;
  assign bus.txSendOUT = send_q;
  assign bus.busyOUT   = busy_q;
  assign bus.errOUT    = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter driving a small UartTX model on the same clock.
// The timeout scenario follows UART_ARB_TIMEOUT_EN when that macro is defined.
module tb_uart_tx_arbiter;
  localparam int NREQ     = 4;
  localparam int TIMEOUT  = 64;
  localparam int BIT_CLKS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .baudClkX2 (clk),
    .resetIN   (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // UartTX model: accepts on sendIN in READY, 10 bits of BIT_CLKS clocks,
  // then reports idle and waits for sendIN low before re-arming.
  typedef enum logic [1:0] {TX_READY, TX_BUSY, TX_WAITLOW} tx_state_e;
  tx_state_e  tx_state = TX_READY;
  logic [9:0] tx_frame = '1;
  int         tx_tick  = 0;
  logic       tx_force_lo = 1'b0;
  logic       tx_stuck    = 1'b0;
  logic [7:0] sent_q[$];
  logic       serial_q[$];

  always @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_READY;
      tx_tick  <= 0;
    end else begin
      case (tx_state)
        TX_READY: if (bus.txSendOUT && !tx_force_lo && !tx_stuck) begin
          tx_frame <= {1'b1, bus.txDataOUT, 1'b0};
          tx_tick  <= 0;
          tx_state <= TX_BUSY;
        end
        TX_BUSY: begin
          if (tx_tick % BIT_CLKS == 0) serial_q.push_back(tx_frame[tx_tick / BIT_CLKS]);
          if (tx_tick == 10 * BIT_CLKS - 1) begin
            sent_q.push_back(tx_frame[8:1]);
            tx_state <= TX_WAITLOW;
          end
          tx_tick <= tx_tick + 1;
        end
        default: if (!bus.txSendOUT) tx_state <= TX_READY;
      endcase
    end
  end

  assign bus.txNBusyIN = tx_force_lo ? 1'b0 : (tx_state != TX_BUSY);

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int err_seen   = 0;
  int low_run    = 0;
  int min_gap    = 1000;
  bit had_byte   = 0;
  logic [NREQ-1:0] ack_log[$];

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got running want done");
    $fatal(1);
  end

  task automatic clear_logs();
    ack_log.delete();
    sent_q.delete();
    serial_q.delete();
    err_seen = 0;
    min_gap  = 1000;
    had_byte = 0;
    low_run  = 0;
  endtask

  // One clock; observe #1 after the edge; requesters drop reqIN on their ack.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ackOUT != '0) begin
      ack_log.push_back(bus.ackOUT);
      bus.reqIN = bus.reqIN & ~bus.ackOUT;
    end
    if (bus.errOUT) err_seen++;
    if (!bus.txSendOUT) begin
      low_run++;
    end else begin
      if (had_byte && low_run > 0 && low_run < min_gap) min_gap = low_run;
      had_byte = 1;
      low_run  = 0;
    end
  endtask

  task automatic run_until_acks(input int n, input int budget, output bit ok);
    int start;
    start = ack_log.size();
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ack_log.size() >= start + n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.grantOUT != '0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.reqIN  = '0;
    bus.dataIN = '0;
    rst = 1'b1;
    repeat (3) step();
    compared++; if (bus.grantOUT !== 4'b0000) begin mismatched++; $display("FAIL reset_grant: got %b want 0000", bus.grantOUT); end
    compared++; if (bus.ackOUT !== 4'b0000) begin mismatched++; $display("FAIL reset_ack: got %b want 0000", bus.ackOUT); end
    compared++; if (bus.txSendOUT !== 1'b0) begin mismatched++; $display("FAIL reset_send: got %b want 0", bus.txSendOUT); end
    compared++; if (bus.txDataOUT !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h want 00", bus.txDataOUT); end
    compared++; if (bus.busyOUT !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busyOUT); end
    compared++; if (bus.errOUT !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b want 0", bus.errOUT); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    logic [9:0] got_bits;
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;
    clear_logs();
    bus.dataIN[7:0] = 8'hA5;
    bus.reqIN = 4'b0001;
    step();
    compared++; if (bus.grantOUT !== 4'b0001) begin mismatched++; $display("FAIL single_grant: got %b want 0001", bus.grantOUT); end
    compared++; if (bus.txSendOUT !== 1'b1) begin mismatched++; $display("FAIL single_send: got %b want 1", bus.txSendOUT); end
    compared++; if (bus.txDataOUT !== 8'hA5) begin mismatched++; $display("FAIL single_data: got %h want a5", bus.txDataOUT); end
    compared++; if (bus.busyOUT !== 1'b1) begin mismatched++; $display("FAIL single_busy: got %b want 1", bus.busyOUT); end
    run_until_acks(1, 200, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL single_ack_wait: got no ack want ack within 200 clocks"); end
    compared++; if (bus.ackOUT !== 4'b0001) begin mismatched++; $display("FAIL single_ack: got %b want 0001", bus.ackOUT); end
    got_bits = '0;
    for (int i = 0; i < 10; i++) got_bits[i] = (i < serial_q.size()) ? serial_q[i] : 1'bx;
    compared++; if (serial_q.size() != 10 || got_bits !== exp_bits) begin mismatched++; $display("FAIL single_serial: got %b (n=%0d) want %b", got_bits, serial_q.size(), exp_bits); end
    step();
    compared++; if (bus.ackOUT !== 4'b0000) begin mismatched++; $display("FAIL single_ack_len: got %b want 0000", bus.ackOUT); end
    compared++; if (bus.grantOUT !== 4'b0000) begin mismatched++; $display("FAIL single_release_grant: got %b want 0000", bus.grantOUT); end
    compared++; if (bus.txSendOUT !== 1'b0) begin mismatched++; $display("FAIL single_release_send: got %b want 0", bus.txSendOUT); end
    step();
    compared++; if (bus.busyOUT !== 1'b0) begin mismatched++; $display("FAIL single_idle_busy: got %b want 0", bus.busyOUT); end
  endtask

  task automatic test_all_req();
    bit ok;
    logic [NREQ-1:0] exp_ack[4];
    logic [7:0] exp_byte[4];
    logic [NREQ-1:0] ga;
    logic [7:0] gb;
    exp_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_byte = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_reset();
    clear_logs();
    bus.dataIN = 32'h44332211;
    bus.reqIN  = 4'b1111;
    run_until_acks(4, 400, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL all_ack_wait: got %0d acks want 4", ack_log.size()); end
    compared++; if (ack_log.size() != 4) begin mismatched++; $display("FAIL all_ack_count: got %0d want 4", ack_log.size()); end
    for (int i = 0; i < 4; i++) begin
      ga = (i < ack_log.size()) ? ack_log[i] : 'x;
      gb = (i < sent_q.size()) ? sent_q[i] : 'x;
      compared++; if (ga !== exp_ack[i]) begin mismatched++; $display("FAIL all_ack_order[%0d]: got %b want %b", i, ga, exp_ack[i]); end
      compared++; if (gb !== exp_byte[i]) begin mismatched++; $display("FAIL all_byte_order[%0d]: got %h want %h", i, gb, exp_byte[i]); end
    end
    compared++; if (min_gap < 2) begin mismatched++; $display("FAIL all_send_gap: got %0d want >=2", min_gap); end
  endtask

  task automatic test_rr_fairness();
    bit ok;
    logic [NREQ-1:0] a1;
    logic [NREQ-1:0] a2;
    clear_logs();
    bus.dataIN[7:0] = 8'h10;
    bus.reqIN = 4'b0001;
    run_until_acks(1, 200, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL rr_first_wait: got no ack want ack"); end
    bus.dataIN[7:0]   = 8'h30;
    bus.dataIN[23:16] = 8'h20;
    bus.reqIN = 4'b0101;
    wait_grant(10, ok);
    compared++; if (bus.grantOUT !== 4'b0100) begin mismatched++; $display("FAIL rr_grant: got %b want 0100", bus.grantOUT); end
    run_until_acks(2, 400, ok);
    a1 = (ack_log.size() > 1) ? ack_log[1] : 'x;
    a2 = (ack_log.size() > 2) ? ack_log[2] : 'x;
    compared++; if (a1 !== 4'b0100) begin mismatched++; $display("FAIL rr_ack2: got %b want 0100", a1); end
    compared++; if (a2 !== 4'b0001) begin mismatched++; $display("FAIL rr_ack3: got %b want 0001", a2); end
    compared++; if (sent_q.size() != 3 || sent_q[1] !== 8'h20 || sent_q[2] !== 8'h30) begin mismatched++; $display("FAIL rr_bytes: got n=%0d want 10,20,30", sent_q.size()); end
  endtask

  task automatic test_data_hold();
    bit ok;
    logic [7:0] gb;
    clear_logs();
    bus.dataIN[7:0] = 8'h5A;
    bus.reqIN = 4'b0001;
    wait_grant(10, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL hold_grant_wait: got no grant want grant"); end
    bus.dataIN[7:0] = 8'hFF;
    run_until_acks(1, 200, ok);
    gb = (sent_q.size() > 0) ? sent_q[0] : 'x;
    compared++; if (gb !== 8'h5A) begin mismatched++; $display("FAIL hold_byte: got %h want 5a", gb); end
  endtask

  task automatic test_tx_blocked();
    bit ok;
    logic [NREQ-1:0] ga;
    clear_logs();
    tx_force_lo = 1'b1;
    bus.dataIN[15:8] = 8'h66;
    bus.reqIN = 4'b0010;
    repeat (8) step();
    compared++; if (bus.grantOUT !== 4'b0000) begin mismatched++; $display("FAIL blocked_grant: got %b want 0000", bus.grantOUT); end
    compared++; if (bus.txSendOUT !== 1'b0) begin mismatched++; $display("FAIL blocked_send: got %b want 0", bus.txSendOUT); end
    tx_force_lo = 1'b0;
    run_until_acks(1, 200, ok);
    ga = (ack_log.size() > 0) ? ack_log[0] : 'x;
    compared++; if (ga !== 4'b0010 || sent_q.size() != 1 || sent_q[0] !== 8'h66) begin mismatched++; $display("FAIL blocked_release: got ack %b n=%0d want ack 0010 byte 66", ga, sent_q.size()); end
  endtask

  task automatic test_reset_in_done();
    bit ok;
    logic [NREQ-1:0] ga;
    clear_logs();
    bus.dataIN[7:0] = 8'h3C;
    bus.reqIN = 4'b0001;
    for (int i = 0; i < 20 && bus.txNBusyIN; i++) step();
    repeat (3) step();
    rst = 1'b1;
    bus.reqIN = '0;
    step();
    rst = 1'b0;
    compared++; if (bus.txSendOUT !== 1'b0) begin mismatched++; $display("FAIL rst_done_send: got %b want 0", bus.txSendOUT); end
    compared++; if (bus.grantOUT !== 4'b0000) begin mismatched++; $display("FAIL rst_done_grant: got %b want 0000", bus.grantOUT); end
    repeat (40) step();
    compared++; if (ack_log.size() != 0) begin mismatched++; $display("FAIL rst_done_noack: got %0d acks want 0", ack_log.size()); end
    bus.dataIN[23:16] = 8'h81;
    bus.reqIN = 4'b0100;
    run_until_acks(1, 200, ok);
    ga = (ack_log.size() > 0) ? ack_log[0] : 'x;
    compared++; if (ga !== 4'b0100 || sent_q.size() != 1 || sent_q[0] !== 8'h81) begin mismatched++; $display("FAIL rst_done_next: got ack %b n=%0d want ack 0100 byte 81", ga, sent_q.size()); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_logs();
    tx_stuck = 1'b1;
    bus.dataIN[7:0] = 8'h77;
    bus.reqIN = 4'b0001;
    wait_grant(10, ok);
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL to_grant_wait: got no grant want grant"); end
`ifdef UART_ARB_TIMEOUT_EN
    begin
      int err_at;
      err_at = -1;
      for (int j = 1; j <= TIMEOUT + 4; j++) begin
        step();
        if (bus.errOUT && err_at < 0) begin
          err_at = j;
          bus.reqIN = '0;
        end
      end
      compared++; if (err_at != TIMEOUT) begin mismatched++; $display("FAIL to_err_time: got %0d want %0d", err_at, TIMEOUT); end
      compared++; if (err_seen != 1) begin mismatched++; $display("FAIL to_err_len: got %0d want 1", err_seen); end
      compared++; if (ack_log.size() != 0) begin mismatched++; $display("FAIL to_noack: got %0d want 0", ack_log.size()); end
      compared++; if (bus.busyOUT !== 1'b0 || bus.grantOUT !== 4'b0000 || bus.txSendOUT !== 1'b0) begin mismatched++; $display("FAIL to_idle: got busy %b grant %b send %b want 0 0000 0", bus.busyOUT, bus.grantOUT, bus.txSendOUT); end
    end
`else
    repeat (TIMEOUT + 20) step();
    compared++; if (err_seen != 0) begin mismatched++; $display("FAIL to_no_err: got %0d want 0", err_seen); end
    compared++; if (bus.busyOUT !== 1'b1 || bus.grantOUT !== 4'b0001 || bus.txSendOUT !== 1'b1) begin mismatched++; $display("FAIL to_stays_send: got busy %b grant %b send %b want 1 0001 1", bus.busyOUT, bus.grantOUT, bus.txSendOUT); end
    compared++; if (ack_log.size() != 0) begin mismatched++; $display("FAIL to_noack: got %0d want 0", ack_log.size()); end
`endif
    tx_stuck  = 1'b0;
    bus.reqIN = '0;
    pulse_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_req();
    test_rr_fairness();
    test_data_hold();
    test_tx_blocked();
    test_reset_in_done();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
